// File: rtl/axi_tdd_ng_cfg_pkg.sv
// Shared types and constants for the axi_tdd_ng configuration master.
//   cfg_state_t : transaction FSM states
//   RESP_*      : AXI response codes used by the master
//   cfg_rsp_t   : captured response returned to the command side
package axi_tdd_ng_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RESP,
        DRAIN
    } cfg_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        timeout;
    } cfg_rsp_t;

endpackage

// File: rtl/axi_tdd_ng_cfg_timeout.sv
// Transaction watchdog for the configuration master.
//   clk, reset : clock and synchronous active-high reset
//   clear      : restart the count (command accept)
//   run        : count while a transaction is waiting on the bus
//   expired    : count has reached TIMEOUT_CYCLES-1
// Only built when AXI_TDD_NG_CFG_TIMEOUT_EN is defined.
module axi_tdd_ng_cfg_timeout
    import axi_tdd_ng_cfg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    assign expired = (count == LAST);

    // Counter saturates at LAST so a late-winning handshake never sees a wrap.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (run && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/axi_tdd_ng_cfg_master.sv
// AXI4-Lite initiator: turns a single-outstanding command stream into
// AXI4-Lite transactions toward the axi_tdd_ng register slave.
//   clk, reset           : single clock, synchronous active-high reset
//   cmd_*                : command in (valid/ready, wr, addr, wdata)
//   rsp_*                : response out (valid/ready, rdata, resp, timeout)
//   m_axi_aw/w/b/ar/r*   : AXI4-Lite master channels
// Build option: define AXI_TDD_NG_CFG_TIMEOUT_EN to include the transaction
// watchdog; without it WRITE/READ wait indefinitely and rsp_timeout stays 0.
module axi_tdd_ng_cfg_master
    import axi_tdd_ng_cfg_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    input  logic [1:0]            m_axi_bresp,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp
);

    cfg_state_t state, state_n;
    logic aw_pend, w_pend, b_pend, ar_pend, r_pend;
    logic aw_pend_n, w_pend_n, b_pend_n, ar_pend_n, r_pend_n;
    logic any_pend_n;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0] wdata_q;
    cfg_rsp_t rsp_q, rsp_n;
    logic accept, b_hs, r_hs, run_timer, expired;
    logic unused_addr_lsb;

    assign accept    = cmd_valid && (state == IDLE);
    assign b_hs      = b_pend && m_axi_bvalid;
    assign r_hs      = r_pend && m_axi_rvalid;
    assign run_timer = (state == WRITE) || (state == READ);

    // Address LSBs are forced to zero on the bus, so the inputs are dropped.
    assign unused_addr_lsb = ^cmd_addr[1:0];

`ifdef AXI_TDD_NG_CFG_TIMEOUT_EN
    axi_tdd_ng_cfg_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .run     (run_timer),
        .expired (expired)
    );
`else
    logic unused_timeout_cfg;
    assign expired            = 1'b0;
    assign unused_timeout_cfg = run_timer ^ (TIMEOUT_CYCLES > 1);
`endif

    // Outputs come straight from registers.
    assign cmd_ready     = (state == IDLE);
    assign rsp_valid     = (state == RESP);
    assign rsp_rdata     = rsp_q.rdata;
    assign rsp_resp      = rsp_q.resp;
    assign rsp_timeout   = rsp_q.timeout;
    assign m_axi_awvalid = aw_pend;
    assign m_axi_wvalid  = w_pend;
    assign m_axi_bready  = b_pend;
    assign m_axi_arvalid = ar_pend;
    assign m_axi_rready  = r_pend;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_wstrb   = 4'hF;

    always_comb begin
        state_n   = state;
        rsp_n     = rsp_q;
        // Each channel retires on its own handshake, in any state.
        aw_pend_n = aw_pend && !m_axi_awready;
        w_pend_n  = w_pend  && !m_axi_wready;
        b_pend_n  = b_pend  && !m_axi_bvalid;
        ar_pend_n = ar_pend && !m_axi_arready;
        r_pend_n  = r_pend  && !m_axi_rvalid;
        any_pend_n = aw_pend_n || w_pend_n || b_pend_n || ar_pend_n || r_pend_n;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_wr) begin
                        aw_pend_n = 1'b1;
                        w_pend_n  = 1'b1;
                        b_pend_n  = 1'b1;
                        state_n   = WRITE;
                    end else begin
                        ar_pend_n = 1'b1;
                        r_pend_n  = 1'b1;
                        state_n   = READ;
                    end
                end
            end
            WRITE: begin
                // A handshake in the expiry cycle takes priority over timeout.
                if (b_hs) begin
                    rsp_n.rdata   = 32'h0;
                    rsp_n.resp    = m_axi_bresp;
                    rsp_n.timeout = 1'b0;
                    state_n       = RESP;
                end else if (expired) begin
                    rsp_n.rdata   = 32'h0;
                    rsp_n.resp    = RESP_SLVERR;
                    rsp_n.timeout = 1'b1;
                    state_n       = RESP;
                end
            end
            READ: begin
                if (r_hs) begin
                    rsp_n.rdata   = m_axi_rdata;
                    rsp_n.resp    = m_axi_rresp;
                    rsp_n.timeout = 1'b0;
                    state_n       = RESP;
                end else if (expired) begin
                    rsp_n.rdata   = 32'h0;
                    rsp_n.resp    = RESP_SLVERR;
                    rsp_n.timeout = 1'b1;
                    state_n       = RESP;
                end
            end
            RESP: begin
                // Late B/R handshakes here are retired but not captured.
                if (rsp_ready) begin
                    state_n = any_pend_n ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (!any_pend_n) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
            b_pend  <= 1'b0;
            ar_pend <= 1'b0;
            r_pend  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rsp_q   <= '0;
        end else begin
            state   <= state_n;
            aw_pend <= aw_pend_n;
            w_pend  <= w_pend_n;
            b_pend  <= b_pend_n;
            ar_pend <= ar_pend_n;
            r_pend  <= r_pend_n;
            rsp_q   <= rsp_n;
            if (accept) begin
                addr_q  <= {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
                wdata_q <= cmd_wdata;
            end
        end
    end

endmodule

// File: tb/tb_axi_tdd_ng_cfg_master.sv
module tb_axi_tdd_ng_cfg_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic        m_axi_awvalid, m_axi_awready = 1'b0;
    logic [15:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_wvalid, m_axi_wready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_bvalid = 1'b0, m_axi_bready;
    logic [1:0]  m_axi_bresp = 2'b00;
    logic        m_axi_arvalid, m_axi_arready = 1'b0;
    logic [15:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_rvalid = 1'b0, m_axi_rready;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = 2'b00;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int prev_acc = -1;
    logic [31:0] mem [0:63];
    logic [31:0] exp_mem [0:63];

    axi_tdd_ng_cfg_master #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_slave();
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0; rsp_ready = 1'b0; cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
        n_cmp++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid} !== 3'b000) begin n_fail++; $display("FAIL rst_valids: got %b want 000", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}); end
        n_cmp++; if ({m_axi_bready, m_axi_rready} !== 2'b00) begin n_fail++; $display("FAIL rst_readies: got %b want 00", {m_axi_bready, m_axi_rready}); end
        n_cmp++; if ({rsp_valid, rsp_timeout, rsp_resp, rsp_rdata} !== 36'h0) begin n_fail++; $display("FAIL rst_rsp: got %h want 0", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}); end
    endtask

    // One command through a zero-wait slave backed by mem[].
    task automatic run_cmd_zw(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                              input logic [31:0] exp_rd, input logic b2b);
        logic [15:0] a_al;
        a_al = {addr[15:2], 2'b00};
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL zw_cmd_ready: got %b want 1", cmd_ready); end
        if (b2b && prev_acc >= 0) begin
            n_cmp++; if (cyc - prev_acc != 4) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 4", cyc - prev_acc); end
        end
        prev_acc = cyc;
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wd;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1; rsp_ready = 1'b1;
        tick(); // N+1
        cmd_valid = 1'b0;
        if (wr) begin
            n_cmp++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid} !== 3'b110) begin n_fail++; $display("FAIL zw_aw_w_valid: got %b want 110", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}); end
            n_cmp++; if ({m_axi_awaddr, m_axi_wdata, m_axi_wstrb, m_axi_awprot} !== {a_al, wd, 4'hF, 3'b000}) begin n_fail++; $display("FAIL zw_aw_w_fields: got %h %h %h %h want %h %h f 0", m_axi_awaddr, m_axi_wdata, m_axi_wstrb, m_axi_awprot, a_al, wd); end
            mem[m_axi_awaddr[7:2]] = m_axi_wdata;
        end else begin
            n_cmp++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid} !== 3'b001) begin n_fail++; $display("FAIL zw_ar_valid: got %b want 001", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}); end
            n_cmp++; if ({m_axi_araddr, m_axi_arprot} !== {a_al, 3'b000}) begin n_fail++; $display("FAIL zw_ar_fields: got %h %h want %h 0", m_axi_araddr, m_axi_arprot, a_al); end
            m_axi_rdata = mem[m_axi_araddr[7:2]];
        end
        tick(); // N+2
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL zw_rsp_early: got %b want 0", rsp_valid); end
        if (wr) begin m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00; end
        else begin m_axi_rvalid = 1'b1; m_axi_rresp = 2'b00; end
        tick(); // N+3
        m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0;
        n_cmp++; if ({rsp_valid, rsp_timeout, rsp_resp} !== 4'b1000) begin n_fail++; $display("FAIL zw_rsp: got v/to/resp %b want 1000", {rsp_valid, rsp_timeout, rsp_resp}); end
        n_cmp++; if (rsp_rdata !== (wr ? 32'h0 : exp_rd)) begin n_fail++; $display("FAIL zw_rdata: got %h want %h", rsp_rdata, wr ? 32'h0 : exp_rd); end
        tick(); // N+4
        n_cmp++; if ({cmd_ready, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL zw_return_idle: got %b want 10", {cmd_ready, rsp_valid}); end
    endtask

    task automatic test_write_zero_wait();
        run_cmd_zw(1'b1, 16'h0040, 32'h0000_0001, 32'h0, 1'b0);
        idle_slave();
    endtask

    task automatic test_write_w_first_slverr();
        idle_slave();
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 16'h0044; cmd_wdata = 32'hCAFE_0002;
        tick(); // N+1
        cmd_valid = 1'b0;
        m_axi_wready = 1'b1;
        tick(); // N+2
        m_axi_wready = 1'b0;
        n_cmp++; if ({m_axi_awvalid, m_axi_wvalid} !== 2'b10) begin n_fail++; $display("FAIL wf_w_drop: got %b want 10", {m_axi_awvalid, m_axi_wvalid}); end
        tick(); // N+3
        n_cmp++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b101) begin n_fail++; $display("FAIL wf_aw_hold: got %b want 101", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}); end
        tick(); // N+4
        m_axi_awready = 1'b1;
        tick(); // N+5
        m_axi_awready = 1'b0;
        n_cmp++; if ({m_axi_awvalid, rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL wf_aw_done: got %b want 00", {m_axi_awvalid, rsp_valid}); end
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b10; rsp_ready = 1'b1;
        tick(); // N+6
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        n_cmp++; if ({rsp_valid, rsp_timeout, rsp_resp} !== 4'b1010) begin n_fail++; $display("FAIL wf_slverr: got v/to/resp %b want 1010", {rsp_valid, rsp_timeout, rsp_resp}); end
        tick(); // N+7
        n_cmp++; if ({cmd_ready, rsp_valid, m_axi_bready} !== 3'b100) begin n_fail++; $display("FAIL wf_single_rsp: got %b want 100", {cmd_ready, rsp_valid, m_axi_bready}); end
        idle_slave();
    endtask

    task automatic test_read_delayed_hold();
        idle_slave();
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h0000; m_axi_arready = 1'b1;
        tick(); // N+1
        cmd_valid = 1'b0;
        n_cmp++; if ({m_axi_arvalid, m_axi_rready, cmd_ready} !== 3'b110) begin n_fail++; $display("FAIL rd_ar: got %b want 110", {m_axi_arvalid, m_axi_rready, cmd_ready}); end
        tick(); // N+2
        m_axi_arready = 1'b0;
        for (int i = 0; i < 4; i++) tick(); // N+6
        n_cmp++; if ({m_axi_arvalid, m_axi_rready, rsp_valid} !== 3'b010) begin n_fail++; $display("FAIL rd_wait_r: got %b want 010", {m_axi_arvalid, m_axi_rready, rsp_valid}); end
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'h5444_4E47; m_axi_rresp = 2'b00;
        tick(); // N+7
        m_axi_rvalid = 1'b0; m_axi_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({rsp_valid, cmd_ready, rsp_resp, rsp_rdata} !== {2'b10, 2'b00, 32'h5444_4E47}) begin n_fail++; $display("FAIL rd_hold%0d: got %b %b %b %h want 1 0 00 54444e47", i, rsp_valid, cmd_ready, rsp_resp, rsp_rdata); end
            tick();
        end
        rsp_ready = 1'b1;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rd_before_consume: got %b want 1", rsp_valid); end
        tick();
        rsp_ready = 1'b0;
        n_cmp++; if ({cmd_ready, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL rd_consumed: got %b want 10", {cmd_ready, rsp_valid}); end
        idle_slave();
    endtask

`ifdef AXI_TDD_NG_CFG_TIMEOUT_EN
    task automatic test_timeout_drain();
        idle_slave();
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h0008;
        tick(); // N+1
        cmd_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick(); // N+16
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b want 0", rsp_valid); end
        rsp_ready = 1'b1;
        tick(); // N+17
        n_cmp++; if ({rsp_valid, rsp_timeout, rsp_resp, rsp_rdata} !== {1'b1, 1'b1, 2'b10, 32'h0}) begin n_fail++; $display("FAIL to_rsp: got %b %b %b %h want 1 1 10 0", rsp_valid, rsp_timeout, rsp_resp, rsp_rdata); end
        n_cmp++; if (m_axi_arvalid !== 1'b1) begin n_fail++; $display("FAIL to_arvalid_kept: got %b want 1", m_axi_arvalid); end
        tick(); // N+18, draining
        rsp_ready = 1'b0;
        n_cmp++; if ({cmd_ready, rsp_valid, m_axi_arvalid} !== 3'b001) begin n_fail++; $display("FAIL to_drain: got %b want 001", {cmd_ready, rsp_valid, m_axi_arvalid}); end
        m_axi_arready = 1'b1;
        tick(); // N+19
        m_axi_arready = 1'b0;
        n_cmp++; if ({cmd_ready, m_axi_arvalid, m_axi_rready} !== 3'b001) begin n_fail++; $display("FAIL to_drain_r: got %b want 001", {cmd_ready, m_axi_arvalid, m_axi_rready}); end
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'h1234_5678;
        tick(); // N+20
        m_axi_rvalid = 1'b0;
        n_cmp++; if ({cmd_ready, rsp_valid, m_axi_rready} !== 3'b100) begin n_fail++; $display("FAIL to_idle: got %b want 100", {cmd_ready, rsp_valid, m_axi_rready}); end
        idle_slave();
    endtask
`endif

    task automatic test_reset_mid_write();
        idle_slave();
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 16'h0048; cmd_wdata = 32'h0BAD_F00D;
        tick(); // N+1
        cmd_valid = 1'b0; m_axi_awready = 1'b1;
        tick(); // N+2: AW accepted, W pending
        m_axi_awready = 1'b0;
        n_cmp++; if ({m_axi_awvalid, m_axi_wvalid} !== 2'b01) begin n_fail++; $display("FAIL mr_pre: got %b want 01", {m_axi_awvalid, m_axi_wvalid}); end
        reset = 1'b1;
        tick(); // N+3
        reset = 1'b0;
        n_cmp++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready} !== 5'b0) begin n_fail++; $display("FAIL mr_valids: got %b want 00000", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}); end
        n_cmp++; if ({cmd_ready, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL mr_cmd_rsp: got %b want 10", {cmd_ready, rsp_valid}); end
    endtask

    task automatic test_back_to_back();
        logic        wr_t [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [15:0] ad_t [8] = '{16'h0010, 16'h0017, 16'h0010, 16'h0018, 16'h0014, 16'h0010, 16'h001B, 16'h0012};
        logic [31:0] wd_t [8] = '{32'h1111_AAAA, 32'h2222_BBBB, 32'h0, 32'h3333_CCCC, 32'h0, 32'h4444_DDDD, 32'h0, 32'h0};
        prev_acc = -1;
        for (int i = 0; i < 8; i++) begin
            if (wr_t[i]) exp_mem[ad_t[i][7:2]] = wd_t[i];
            run_cmd_zw(wr_t[i], ad_t[i], wd_t[i], exp_mem[ad_t[i][7:2]], 1'b1);
        end
        idle_slave();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin mem[i] = 32'h0; exp_mem[i] = 32'h0; end
        test_reset();
        test_write_zero_wait();
        test_write_w_first_slverr();
        test_read_delayed_hold();
`ifdef AXI_TDD_NG_CFG_TIMEOUT_EN
        test_timeout_drain();
`endif
        test_reset_mid_write();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
